ex_stage: RTL

- Execute stage that consumes the ID/EX pipeline register outputs.
- Single-cycle ALU ops pass through in one cycle. MULTU/DIVU run as a 32-iteration sequential unit that writes internal HI/LO, and back-pressures upstream with ex_stall.
- Contains the EX/MEM output register, so results reach the MEM stage registered.

---
 rtl/ex_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration sequential MULTU/DIVU unit
// that owns HI/LO, followed by the EX/MEM output register.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] ex_num1,
  input  logic [WIDTH-1:0] ex_num2,
  input  logic             ex_regWriteEn,
  input  logic [4:0]       ex_regWriteAddr,
  input  logic [3:0]       ex_aluOp,
  output logic             ex_stall,
  output logic [WIDTH-1:0] mem_result,
  output logic             mem_regWriteEn,
  output logic [4:0]       mem_regWriteAddr
);
  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] opb, acc_hi, acc_lo, hi, lo;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, alu_res, diff;
  logic [WIDTH:0]   sum, shl_rem;
  logic [SW-1:0]    sh;
  logic             is_mdu, last_iter;

  assign is_mdu    = (ex_aluOp == 4'd11) || (ex_aluOp == 4'd12);
  assign last_iter = (state == BUSY) && (cnt == LAST);
  assign ex_stall  = ((state == IDLE) && is_mdu) || ((state == BUSY) && (cnt != LAST));
  assign sh        = ex_num1[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex_aluOp)
      4'd1:  alu_res = ex_num1 + ex_num2;
      4'd2:  alu_res = ex_num1 - ex_num2;
      4'd3:  alu_res = ex_num1 & ex_num2;
      4'd4:  alu_res = ex_num1 | ex_num2;
      4'd5:  alu_res = ex_num1 ^ ex_num2;
      4'd6:  alu_res = ~(ex_num1 | ex_num2);
      4'd7:  alu_res = WIDTH'($signed(ex_num1) < $signed(ex_num2));
      4'd8:  alu_res = ex_num2 << sh;
      4'd9:  alu_res = ex_num2 >> sh;
      4'd10: alu_res = $signed(ex_num2) >>> sh;
      4'd13: alu_res = hi;
      4'd14: alu_res = lo;
      4'd15: alu_res = WIDTH'(ex_num1 < ex_num2);
      default: alu_res = '0;
    endcase
  end

  // One iteration: multiply shifts the {hi,lo} accumulator right after a
  // conditional add; divide shifts left and restores on a failed subtract.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shl_rem = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shl_rem[WIDTH-1:0] - opb;
    nxt_hi  = sum[WIDTH:1];
    nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (shl_rem >= {1'b0, opb}) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shl_rem[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (is_mdu) state_nxt = BUSY;
      BUSY: if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      cnt              <= '0;
      is_div           <= 1'b0;
      opb              <= '0;
      acc_hi           <= '0;
      acc_lo           <= '0;
      hi               <= '0;
      lo               <= '0;
      mem_result       <= '0;
      mem_regWriteEn   <= 1'b0;
      mem_regWriteAddr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && is_mdu) begin
        cnt    <= '0;
        is_div <= (ex_aluOp == 4'd12);
        opb    <= (ex_aluOp == 4'd12) ? ex_num2 : ex_num1;
        acc_lo <= (ex_aluOp == 4'd12) ? ex_num1 : ex_num2;
        acc_hi <= '0;
      end else if (state == BUSY) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
      end
      if (last_iter) begin
        hi <= nxt_hi;
        lo <= nxt_lo;
      end
      // MULTU/DIVU occupy EX with bubbles; only plain ALU ops reach MEM.
      if (state == IDLE && !is_mdu) begin
        mem_result       <= alu_res;
        mem_regWriteEn   <= ex_regWriteEn;
        mem_regWriteAddr <= ex_regWriteAddr;
      end else begin
        mem_result       <= '0;
        mem_regWriteEn   <= 1'b0;
        mem_regWriteAddr <= '0;
      end
    end
  end
endmodule
